// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that merges NUM_REQ requester streams into the
// write port of a downstream asynchronous FIFO.
//
// Ports:
//   wr_clk, wr_rst_n : write-domain clock, asynchronous active-low reset
//   arb_en           : allows new grants (never aborts a running burst)
//   req_valid        : per-requester valid
//   req_data         : packed payloads, requester i at [i*WIDTH +: WIDTH]
//   req_ready        : per-requester beat accepted (combinational)
//   fifo_full        : FIFO write-side full flag
//   fifo_wr_en       : FIFO write strobe (combinational)
//   fifo_wr_data     : {source id, payload} (combinational)
//   grant            : registered one-hot grant, zero when idle
//   busy             : high while a burst is granted
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_LEN = 4,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst_n,
  input  logic                     arb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [ID_W+WIDTH-1:0]    fifo_wr_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]      gid_q, gid_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]           beat_cnt_q, beat_cnt_d;

  logic [2*NUM_REQ-1:0] valid_rot;
  logic [ID_W-1:0]      rr_off;
  logic                 rr_found;
  logic [ID_W:0]        rr_sum;
  logic [WIDTH-1:0]     g_payload;
  logic                 g_valid;
  logic                 beat;

  // Round-robin search: rotate valids so rr_ptr sits at bit 0, take the
  // lowest set bit, then rotate the offset back into a requester index.
  always_comb begin
    valid_rot = {req_valid, req_valid} >> rr_ptr_q;
    rr_off    = '0;
    rr_found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        rr_off   = ID_W'(k);
        rr_found = 1'b1;
      end
    end
    rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
    if (rr_sum >= (ID_W+1)'(NUM_REQ)) begin
      rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
    end
  end

  // Granted requester's valid and payload.
  always_comb begin
    g_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_payload = req_data[i*WIDTH +: WIDTH];
      end
    end
    g_valid = |(grant_q & req_valid);
    beat    = (state_q == S_GRANT) && g_valid && !fifo_full;
  end

  // Next-state and beat outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gid_d        = gid_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    fifo_wr_en   = 1'b0;
    req_ready    = '0;
    fifo_wr_data = {gid_q, g_payload};

    case (state_q)
      S_IDLE: begin
        if (arb_en && rr_found) begin
          state_d    = S_GRANT;
          gid_d      = rr_sum[ID_W-1:0];
          grant_d    = NUM_REQ'(1) << rr_sum[ID_W-1:0];
          beat_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (beat) begin
          fifo_wr_en = 1'b1;
          req_ready  = grant_q;
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        // Stalls (valid but full) fall through both branches and hold.
        if (!g_valid || (beat && (beat_cnt_q == 8'(BURST_LEN - 1)))) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          rr_ptr_d = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gid_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gid_q      <= gid_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks for fifo_wr_arbiter (4 requesters, 8-bit
// payload, 4-beat bursts).
module tb_fifo_wr_arbiter;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned ID_W      = 2;

  logic                     wr_clk;
  logic                     wr_rst_n;
  logic                     arb_en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [ID_W+WIDTH-1:0]    fifo_wr_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;

  logic [WIDTH-1:0] pay [NUM_REQ];
  int n_assert;
  int n_fail;
  int wr_seen;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_REQ   (NUM_REQ),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .arb_en       (arb_en),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pay
    assign req_data[gi*WIDTH +: WIDTH] = pay[gi];
  end

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample 1 ns later.
  task automatic cyc(input logic [3:0] v, input logic full, input logic en);
    @(posedge wr_clk);
    #1;
    req_valid = v;
    fifo_full = full;
    arb_en    = en;
    #1;
    if (fifo_wr_en === 1'b1) wr_seen++;
  endtask

  task automatic beat_chk(input string tag, input int g, input logic [7:0] p);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd1);
    chk({tag, "_grant"}, 32'(grant), 32'(1) << g);
    chk({tag, "_ready"}, 32'(req_ready), 32'(1) << g);
    chk({tag, "_data"},  32'(fifo_wr_data), 32'({2'(g), p}));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    wr_rst_n  = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    arb_en    = 1'b1;
    #1;
    idle_chk("in_reset");
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
  endtask

  int g;
  int base;
  logic [7:0] snd [NUM_REQ];
  logic [7:0] expd [NUM_REQ];
  logic [NUM_REQ-1:0] acc;
  logic [ID_W-1:0] id;
  int total;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    wr_seen  = 0;
    for (int i = 0; i < NUM_REQ; i++) pay[i] = '0;

    // Full contention: grants 0,1,2,3,0, four beats each, one bubble between.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      g = n % NUM_REQ;
      cyc(4'hF, 1'b0, 1'b1);
      idle_chk("rr_bubble");
      for (int b = 0; b < 4; b++) begin
        pay[g] = 8'(16 * g + b);
        cyc(4'hF, 1'b0, 1'b1);
        beat_chk("rr_beat", g, 8'(16 * g + b));
      end
    end
    cyc(4'hF, 1'b0, 1'b1);
    idle_chk("rr_tail");

    // Single requester 2 drops valid after two beats.
    do_reset();
    cyc(4'b0100, 1'b0, 1'b1);
    idle_chk("short_idle");
    for (int b = 0; b < 2; b++) begin
      pay[2] = 8'(8'hA0 + b);
      cyc(4'b0100, 1'b0, 1'b1);
      beat_chk("short_beat", 2, 8'(8'hA0 + b));
    end
    cyc(4'b0000, 1'b0, 1'b1);
    chk("short_exit_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("short_exit_grant", 32'(grant), 32'b0100);
    chk("short_exit_busy",  32'(busy), 32'd1);
    cyc(4'b0000, 1'b0, 1'b1);
    idle_chk("short_after");
    pay[3] = 8'h33;
    cyc(4'b1101, 1'b0, 1'b1);
    idle_chk("short_arb");
    cyc(4'b1101, 1'b0, 1'b1);
    beat_chk("short_rr_ptr3", 3, 8'h33);

    // Stall for five cycles after beat 1 of a grant to requester 1.
    do_reset();
    cyc(4'b0010, 1'b0, 1'b1);
    idle_chk("stall_idle");
    base = wr_seen;
    pay[1] = 8'h10;
    cyc(4'b0010, 1'b0, 1'b1);
    beat_chk("stall_b1", 1, 8'h10);
    repeat (5) begin
      cyc(4'b0010, 1'b1, 1'b1);
      chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_grant", 32'(grant), 32'b0010);
    end
    for (int b = 1; b < 4; b++) begin
      pay[1] = 8'(8'h10 + b);
      cyc(4'b0010, 1'b0, 1'b1);
      beat_chk("stall_resume", 1, 8'(8'h10 + b));
    end
    cyc(4'b0000, 1'b0, 1'b1);
    idle_chk("stall_done");
    chk("stall_total_writes", 32'(wr_seen - base), 32'd4);

    // arb_en dropped at beat 2 of a grant to requester 0.
    do_reset();
    cyc(4'b0011, 1'b0, 1'b1);
    idle_chk("en_idle");
    for (int b = 0; b < 4; b++) begin
      pay[0] = 8'(8'h50 + b);
      cyc(4'b0011, 1'b0, (b == 0) ? 1'b1 : 1'b0);
      beat_chk("en_beat", 0, 8'(8'h50 + b));
    end
    repeat (3) begin
      cyc(4'b0011, 1'b0, 1'b0);
      idle_chk("en_blocked");
    end
    pay[1] = 8'h61;
    cyc(4'b0011, 1'b0, 1'b1);
    idle_chk("en_reenable");
    cyc(4'b0011, 1'b0, 1'b1);
    beat_chk("en_next_grant", 1, 8'h61);

    // Reset pulsed mid-burst at beat 3.
    do_reset();
    cyc(4'hF, 1'b0, 1'b1);
    idle_chk("rst_idle");
    for (int b = 0; b < 3; b++) begin
      pay[0] = 8'(8'h70 + b);
      cyc(4'hF, 1'b0, 1'b1);
      beat_chk("rst_beat", 0, 8'(8'h70 + b));
    end
    wr_rst_n = 1'b0;
    #1;
    idle_chk("rst_mid_burst");
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    #1;
    idle_chk("rst_release");
    pay[0] = 8'h7F;
    cyc(4'hF, 1'b0, 1'b1);
    beat_chk("rst_first_grant", 0, 8'h7F);

    // Random traffic with per-source sequence scoreboard.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      snd[i]  = '0;
      expd[i] = '0;
      pay[i]  = '0;
    end
    acc   = '0;
    total = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge wr_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) snd[i] = snd[i] + 8'd1;
        pay[i] = snd[i];
      end
      req_valid = 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      arb_en    = ($urandom_range(0, 9) != 0);
      #1;
      chk("rnd_no_wr_when_full", 32'(fifo_wr_en & fifo_full), 32'd0);
      chk("rnd_grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("rnd_ready_in_grant", 32'(req_ready & ~grant), 32'd0);
      if (fifo_wr_en === 1'b1) begin
        id = fifo_wr_data[ID_W+WIDTH-1:WIDTH];
        chk("rnd_ready_on_write", 32'(req_ready), 32'(1) << id);
        chk("rnd_sb_data", 32'(fifo_wr_data[WIDTH-1:0]), 32'(expd[id]));
        expd[id] = expd[id] + 8'd1;
        total++;
      end else begin
        chk("rnd_no_ready_without_write", 32'(req_ready), 32'd0);
      end
      acc = req_ready;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) snd[i] = snd[i] + 8'd1;
      chk("rnd_stream_count", 32'(expd[i]), 32'(snd[i]));
    end
    chk("rnd_some_writes", 32'(total > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width per requester.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats per grant (1..255).
REQ-004 SHALL have derived parameter ID_W = max(1, $clog2(NUM_REQ)).
REQ-005 SHALL have port wr_clk, input, 1, write-domain clock.
REQ-006 SHALL have port wr_rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port arb_en, input, 1, permits new grants when high.
REQ-008 SHALL have port req_valid, input, NUM_REQ, per-requester data valid.
REQ-009 SHALL have port req_data, input, NUM_REQ*WIDTH, packed payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port req_ready, output, NUM_REQ, per-requester beat accepted.
REQ-011 SHALL have port fifo_full, input, 1, full flag of the downstream async FIFO write port.
REQ-012 SHALL have port fifo_wr_en, output, 1, FIFO write strobe.
REQ-013 SHALL have port fifo_wr_data, output, ID_W+WIDTH, concatenation {source id, payload}.
REQ-014 SHALL have port grant, output, NUM_REQ, one-hot registered grant; all zero when idle.
REQ-015 SHALL have port busy, output, 1, high while in the GRANT state.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-017 In IDLE with arb_en=1 and any req_valid bit set, SHALL select the winner round-robin, searching upward (with wrap) from rr_ptr, and SHALL register grant=onehot(winner) and enter GRANT on the next edge.
REQ-018 In IDLE with arb_en=0, or with no req_valid bit set, SHALL remain in IDLE with grant=0.
REQ-019 In GRANT for requester g, a beat SHALL occur in a cycle iff req_valid[g]=1 and fifo_full=0.
REQ-020 On a beat, outputs SHALL be combinational in the same cycle: fifo_wr_en=1, req_ready[g]=1, fifo_wr_data={g, req_data[g]}.
REQ-021 req_ready SHALL be 0 for every non-granted requester at all times.
REQ-022 req_ready and fifo_wr_en SHALL be 0 in every cycle without a beat, including all IDLE cycles.
REQ-023 SHALL keep an 8-bit beat counter, cleared on entry to GRANT and incremented once per beat.
REQ-024 SHALL exit GRANT to IDLE when either:
 - a beat occurs with beat counter = BURST_LEN-1; or
 - req_valid[g]=0 in a GRANT cycle.
REQ-025 On exit from GRANT, SHALL set rr_ptr=(g+1) mod NUM_REQ and clear grant.
REQ-026 Each exit SHALL be followed by one IDLE cycle; grant-to-grant spacing is therefore at least 1 bubble cycle.
REQ-027 A stall (fifo_full=1 with req_valid[g]=1) SHALL hold GRANT and the beat counter indefinitely.
REQ-028 A stall SHALL neither count as a beat nor cause an exit.
REQ-029 Deasserting arb_en during GRANT SHALL NOT abort the current burst; it only blocks the next grant.
REQ-030 Latency from req_valid rising in IDLE to the first beat SHALL be 1 cycle, provided fifo_full=0.
REQ-031 SHALL never assert fifo_wr_en while fifo_full=1, so no write to the FIFO is ever dropped.

Reset
REQ-032 On wr_rst_n=0, SHALL asynchronously force: state=IDLE, grant=0, busy=0, beat counter=0, rr_ptr=0.
REQ-033 During reset, req_ready and fifo_wr_en SHALL be 0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst without issuing further writes.
REQ-035 After reset release, the first arbitration SHALL favour requester 0.

Verification
REQ-036 After reset, req_valid=4'b1111 held, fifo_full=0 -> grants in order 0,1,2,3,0, each exactly 4 beats, with 1 idle cycle between grants.
REQ-037 req_valid[2] only, deasserted after 2 beats -> exactly 2 writes with fifo_wr_data ID field=2, then IDLE; rr_ptr=3.
REQ-038 During a grant to requester 1, fifo_full=1 for 5 cycles after beat 1 -> fifo_wr_en=0 and req_ready=0 during the stall; beats 2-4 resume afterwards; total writes=4.
REQ-039 arb_en dropped at beat 2 of a grant to requester 0 -> burst completes all 4 beats, then grant=0 while arb_en=0 despite pending req_valid.
REQ-040 wr_rst_n pulsed low at beat 3 -> fifo_wr_en=0 immediately; after release, requester 0 is granted first.
REQ-041 Random valid/full traffic across all requesters -> scoreboard shows per-source in-order data with none lost or duplicated; no fifo_wr_en while fifo_full=1; grant always one-hot or zero.
